pll_bringup_sequencer: RTL and testbench

PLL_BRINGUP_SEQUENCER -- requirements
Module: pll_bringup_sequencer

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/lock_window_checker.sv | 81 ++++++++
 rtl/pll_bringup_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_bringup_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default tuning constants for the PLL bring-up sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CP_EN     = 3'd1,
    ST_VCO_EN    = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_RST_HOLD  = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_t;

  localparam int DEF_REF_WIN   = 8;
  localparam int DEF_MULT      = 8;
  localparam int DEF_TOL       = 1;
  localparam int DEF_LOCK_GOOD = 4;
  localparam int DEF_CP_DLY    = 16;
  localparam int DEF_VCO_DLY   = 16;
  localparam int DEF_RST_HOLD  = 32;
  localparam int DEF_TIMEOUT   = 4096;
  localparam int DEF_MAX_RETRY = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_window_checker.sv
// Synchronizes REF/FB, counts FB edges per REF_WIN reference edges and
// emits one-cycle good/bad pulses when each window closes.
module lock_window_checker
  import pll_seq_pkg::*;
#(
  parameter int REF_WIN = DEF_REF_WIN,
  parameter int MULT    = DEF_MULT,
  parameter int TOL     = DEF_TOL
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic ref_in,
  input  logic fb_in,
  output logic win_good,
  output logic win_bad
);

  localparam int FBW = $clog2(2 * REF_WIN * MULT + 1);
  localparam int RW  = (REF_WIN > 1) ? $clog2(REF_WIN) : 1;
  localparam logic [FBW-1:0] FB_MAX   = '1;
  localparam logic [FBW-1:0] TARGET_V = FBW'(REF_WIN * MULT);
  localparam logic [FBW-1:0] TOL_V    = FBW'(TOL);
  localparam logic [RW-1:0]  LAST_REF = RW'(REF_WIN - 1);

  logic [2:0]     ref_sync;
  logic [2:0]     fb_sync;
  logic           ref_edge;
  logic           fb_edge;
  logic           armed;
  logic [RW-1:0]  ref_cnt;
  logic [FBW-1:0] fb_cnt;
  logic [FBW-1:0] fb_dist;
  logic           good_now;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_in};
      fb_sync  <= {fb_sync[1:0], fb_in};
    end
  end

  assign ref_edge = ref_sync[1] & ~ref_sync[2];
  assign fb_edge  = fb_sync[1] & ~fb_sync[2];

  assign fb_dist  = (fb_cnt >= TARGET_V) ? (fb_cnt - TARGET_V) : (TARGET_V - fb_cnt);
  assign good_now = (fb_cnt != FB_MAX) && (fb_dist <= TOL_V);

  // An FB edge coincident with the closing REF edge belongs to the new window.
  always_ff @(posedge clk) begin
    if (!reset_n || !active) begin
      armed    <= 1'b0;
      ref_cnt  <= '0;
      fb_cnt   <= '0;
      win_good <= 1'b0;
      win_bad  <= 1'b0;
    end else begin
      win_good <= 1'b0;
      win_bad  <= 1'b0;
      if (!armed) begin
        if (ref_edge) begin
          armed   <= 1'b1;
          ref_cnt <= '0;
          fb_cnt  <= FBW'(fb_edge);
        end
      end else if (ref_edge && (ref_cnt == LAST_REF)) begin
        win_good <= good_now;
        win_bad  <= !good_now;
        ref_cnt  <= '0;
        fb_cnt   <= FBW'(fb_edge);
      end else begin
        if (ref_edge) ref_cnt <= ref_cnt + 1'b1;
        if (fb_edge && (fb_cnt != FB_MAX)) fb_cnt <= fb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_bringup_sequencer.sv
// PLL bring-up sequencer: enables CP then VCO, qualifies lock over
// measurement windows, releases core reset, and retries or faults.
//
//   state     | meaning
//   IDLE      | PLL off, core held in reset, waiting for start
//   CP_EN     | charge pump on, settling
//   VCO_EN    | charge pump and VCO on, settling
//   LOCK_WAIT | counting consecutive good windows, timeout armed
//   RST_HOLD  | locked, core reset still held
//   RUN       | core running, lock monitored
//   FAULT     | retries exhausted, PLL off until start drops
module pll_bringup_sequencer
  import pll_seq_pkg::*;
#(
  parameter int REF_WIN   = DEF_REF_WIN,
  parameter int MULT      = DEF_MULT,
  parameter int TOL       = DEF_TOL,
  parameter int LOCK_GOOD = DEF_LOCK_GOOD,
  parameter int CP_DLY    = DEF_CP_DLY,
  parameter int VCO_DLY   = DEF_VCO_DLY,
  parameter int RST_HOLD  = DEF_RST_HOLD,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ref_in,
  input  logic       fb_in,
  output logic       ENb_CP,
  output logic       ENb_VCO,
  output logic       core_reset,
  output logic       locked,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt
);

  localparam int TW = $clog2(max_of(max_of(CP_DLY, VCO_DLY), max_of(RST_HOLD, TIMEOUT))) + 1;
  localparam int GW = $clog2(LOCK_GOOD + 1);

  seq_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          bad_seen, bad_nxt;
  logic [1:0]    retry_nxt;
  logic          fault_nxt;
  logic          cp_nxt, vco_nxt, crst_nxt, lock_nxt;
  logic          chk_active;
  logic          win_good, win_bad;

  assign chk_active = (state == ST_LOCK_WAIT) || (state == ST_RST_HOLD) || (state == ST_RUN);

  lock_window_checker #(
    .REF_WIN (REF_WIN),
    .MULT    (MULT),
    .TOL     (TOL)
  ) u_lock_chk (
    .clk      (CLK),
    .reset_n  (reset_n),
    .active   (chk_active),
    .ref_in   (ref_in),
    .fb_in    (fb_in),
    .win_good (win_good),
    .win_bad  (win_bad)
  );

  always_comb begin
    state_nxt = state;
    timer_nxt = (timer != '0) ? (timer - 1'b1) : timer;
    good_nxt  = good_cnt;
    bad_nxt   = bad_seen;
    retry_nxt = retry_cnt;
    fault_nxt = fault;

    case (state)
      ST_IDLE: if (start) state_nxt = ST_CP_EN;
      ST_CP_EN: if (timer == '0) state_nxt = ST_VCO_EN;
      ST_VCO_EN: if (timer == '0) state_nxt = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        if (win_good) good_nxt = good_cnt + 1'b1;
        else if (win_bad) good_nxt = '0;
        // Lock qualification wins over a simultaneous timeout.
        if (win_good && (good_cnt == GW'(LOCK_GOOD - 1))) begin
          state_nxt = ST_RST_HOLD;
        end else if (timer == '0) begin
          retry_nxt = (retry_cnt == 2'd3) ? retry_cnt : (retry_cnt + 1'b1);
          state_nxt = (int'(retry_nxt) < MAX_RETRY) ? ST_CP_EN : ST_FAULT;
        end
      end
      ST_RST_HOLD: if (timer == '0) state_nxt = ST_RUN;
      ST_RUN: begin
        if (win_bad) begin
          if (bad_seen) state_nxt = ST_CP_EN;
          else bad_nxt = 1'b1;
        end else if (win_good) begin
          bad_nxt = 1'b0;
        end
      end
      ST_FAULT: if (!start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (!start && (state != ST_FAULT)) state_nxt = ST_IDLE;

    if (state_nxt != state) begin
      case (state_nxt)
        ST_IDLE: begin
          retry_nxt = '0;
          fault_nxt = 1'b0;
        end
        ST_CP_EN:     timer_nxt = TW'(CP_DLY - 1);
        ST_VCO_EN:    timer_nxt = TW'(VCO_DLY - 1);
        ST_LOCK_WAIT: begin
          timer_nxt = TW'(TIMEOUT - 1);
          good_nxt  = '0;
        end
        ST_RST_HOLD:  timer_nxt = TW'(RST_HOLD - 1);
        ST_RUN:       bad_nxt = 1'b0;
        ST_FAULT:     fault_nxt = 1'b1;
        default: ;
      endcase
    end

    cp_nxt   = 1'b1;
    vco_nxt  = 1'b1;
    crst_nxt = 1'b1;
    lock_nxt = 1'b0;
    case (state_nxt)
      ST_IDLE, ST_FAULT: begin
        cp_nxt  = 1'b0;
        vco_nxt = 1'b0;
      end
      ST_CP_EN: vco_nxt = 1'b0;
      ST_RUN: begin
        crst_nxt = 1'b0;
        lock_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      good_cnt   <= '0;
      bad_seen   <= 1'b0;
      retry_cnt  <= '0;
      fault      <= 1'b0;
      ENb_CP     <= 1'b0;
      ENb_VCO    <= 1'b0;
      core_reset <= 1'b1;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      good_cnt   <= good_nxt;
      bad_seen   <= bad_nxt;
      retry_cnt  <= retry_nxt;
      fault      <= fault_nxt;
      ENb_CP     <= cp_nxt;
      ENb_VCO    <= vco_nxt;
      core_reset <= crst_nxt;
      locked     <= lock_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_bringup_sequencer.sv
// Directed bench for the PLL bring-up sequencer: ideal lock, reset and
// fb-loss in RUN, start priority, tolerance boundaries and retry exhaustion.
module tb_pll_bringup_sequencer;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic       ENb_CP, ENb_VCO, core_reset, locked, fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;

  int n_vec = 0;
  int n_err = 0;

  // REF: 40 clocks per period. FB: a pulse every 4 clocks, fb_base pulses per
  // REF period, plus fb_extra in the first period of every 8 -> any 8
  // consecutive periods hold exactly 8*fb_base + fb_extra edges.
  int cyc = 0;
  int fb_base = 8;
  int fb_extra = 0;
  int g_per, g_off, g_n;

  pll_bringup_sequencer dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .ENb_CP     (ENb_CP),
    .ENb_VCO    (ENb_VCO),
    .core_reset (core_reset),
    .locked     (locked),
    .fault      (fault),
    .state_o    (state_o),
    .retry_cnt  (retry_cnt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    g_per = cyc / 40;
    g_off = cyc % 40;
    g_n = (g_per == 0) ? (fb_base + fb_extra) : fb_base;
    ref_in = (g_off < 20);
    fb_in = (g_off >= 2) && (((g_off - 2) / 4) < g_n) && (((g_off - 2) % 4) < 2);
    cyc = (cyc == 319) ? 0 : cyc + 1;
  end

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, output int n);
    n = 0;
    while ((int'(state_o) != s) && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  task automatic align();
    int k;
    k = 0;
    while ((cyc != 100) && (k < 400)) begin
      tick();
      k++;
    end
  endtask

  int lock_lat;
  int n;
  int seen4;
  int tol_extra[4] = '{-1, 1, -2, 2};
  int tol_good[4]  = '{1, 1, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check_vec("rst_state", state_o, 0);
    check_vec("rst_cp", ENb_CP, 0);
    check_vec("rst_vco", ENb_VCO, 0);
    check_vec("rst_core_reset", core_reset, 1);
    check_vec("rst_locked", locked, 0);
    check_vec("rst_fault", fault, 0);
    check_vec("rst_retry", retry_cnt, 0);
    reset_n = 1'b1;
    tick();

    // ideal lock, 64 edges per window
    align();
    start = 1'b1;
    tick();
    check_vec("c1_state", state_o, 1);
    check_vec("c1_cp", ENb_CP, 1);
    check_vec("c1_vco", ENb_VCO, 0);
    repeat (15) tick();
    check_vec("c16_vco", ENb_VCO, 0);
    tick();
    check_vec("c17_vco", ENb_VCO, 1);
    check_vec("c17_state", state_o, 2);
    repeat (16) tick();
    check_vec("c33_state", state_o, 3);
    wait_state(4, 4000, n);
    lock_lat = 33 + n;
    check_vec("lock_rst_hold", state_o, 4);
    check_vec("lock_core_reset", core_reset, 1);
    check_vec("lock_locked_early", locked, 0);
    repeat (31) tick();
    check_vec("hold31_state", state_o, 4);
    tick();
    check_vec("run_state", state_o, 5);
    check_vec("run_locked", locked, 1);
    check_vec("run_core_reset", core_reset, 0);

    // one-cycle reset in RUN
    reset_n = 1'b0;
    tick();
    check_vec("mid_rst_state", state_o, 0);
    check_vec("mid_rst_cp", ENb_CP, 0);
    check_vec("mid_rst_vco", ENb_VCO, 0);
    check_vec("mid_rst_core_reset", core_reset, 1);
    check_vec("mid_rst_locked", locked, 0);
    reset_n = 1'b1;
    tick();
    check_vec("mid_rst_restart", state_o, 1);
    wait_state(5, 5000, n);
    check_vec("relock_after_rst", state_o, 5);

    // fb lost in RUN
    fb_base = 0;
    n = 0;
    while ((state_o == 3'd5) && (n < 2000)) begin
      tick();
      n++;
    end
    check_vec("fbloss_state", state_o, 1);
    check_vec("fbloss_locked", locked, 0);
    check_vec("fbloss_core_reset", core_reset, 1);
    check_vec("fbloss_retry", retry_cnt, 0);
    fb_base = 8;
    wait_state(5, 6000, n);
    check_vec("fbloss_relock", state_o, 5);
    check_vec("fbloss_relock_retry", retry_cnt, 0);

    // start drop on the edge that would enter RST_HOLD
    start = 1'b0;
    tick();
    check_vec("stop_state", state_o, 0);
    check_vec("stop_cp", ENb_CP, 0);
    check_vec("stop_core_reset", core_reset, 1);
    align();
    start = 1'b1;
    repeat (lock_lat - 1) tick();
    check_vec("pre_close_state", state_o, 3);
    start = 1'b0;
    tick();
    check_vec("start0_priority", state_o, 0);
    tick();
    check_vec("start0_stays_idle", state_o, 0);

    // tolerance boundaries: 63/65 lock, 62/66 do not
    for (int i = 0; i < 4; i++) begin
      fb_extra = tol_extra[i];
      repeat (5) tick();
      start = 1'b1;
      if (tol_good[i] == 1) begin
        wait_state(4, 2600, n);
        check_vec($sformatf("tol_%0d_lock", 64 + tol_extra[i]), state_o, 4);
      end else begin
        seen4 = 0;
        repeat (3000) begin
          tick();
          if (state_o == 3'd4) seen4 = 1;
        end
        check_vec($sformatf("tol_%0d_no_lock", 64 + tol_extra[i]), seen4, 0);
        check_vec($sformatf("tol_%0d_waiting", 64 + tol_extra[i]), state_o, 3);
      end
      start = 1'b0;
      tick();
    end

    // ratio 9: retries every 4128 cycles then FAULT
    fb_extra = 0;
    fb_base = 9;
    repeat (5) tick();
    start = 1'b1;
    for (int t = 1; t <= 12385; t++) begin
      tick();
      case (t)
        4128: begin
          check_vec("r9_t4128_retry", retry_cnt, 0);
          check_vec("r9_t4128_state", state_o, 3);
        end
        4129: begin
          check_vec("r9_t4129_retry", retry_cnt, 1);
          check_vec("r9_t4129_state", state_o, 1);
          check_vec("r9_t4129_vco", ENb_VCO, 0);
        end
        8256: check_vec("r9_t8256_retry", retry_cnt, 1);
        8257: begin
          check_vec("r9_t8257_retry", retry_cnt, 2);
          check_vec("r9_t8257_state", state_o, 1);
        end
        12384: begin
          check_vec("r9_t12384_state", state_o, 3);
          check_vec("r9_t12384_fault", fault, 0);
        end
        12385: begin
          check_vec("r9_fault_retry", retry_cnt, 3);
          check_vec("r9_fault_state", state_o, 6);
          check_vec("r9_fault_flag", fault, 1);
          check_vec("r9_fault_cp", ENb_CP, 0);
          check_vec("r9_fault_vco", ENb_VCO, 0);
          check_vec("r9_fault_core_reset", core_reset, 1);
        end
        default: ;
      endcase
    end
    repeat (10) tick();
    check_vec("fault_sticky", fault, 1);
    start = 1'b0;
    tick();
    check_vec("fault_exit_state", state_o, 0);
    check_vec("fault_exit_flag", fault, 0);
    check_vec("fault_exit_retry", retry_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
